// File: rtl/ul8_alu_pkg.sv
// Shared widths, op codes and FSM encoding for the 8-bit ALU arbiter.
// The arbiter only forwards op codes; the constants document the attached ALU.
package ul8_alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_NAND = 2'b01;
  localparam logic [OP_W-1:0] OP_SUB  = 2'b10;
  localparam logic [OP_W-1:0] OP_XOR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_arb_grant.sv
// Two-way grant decision: a lone valid requester always wins, and a tie goes
// to the requester that was not granted last.
module alu_arb_grant (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters through an IDLE/EXEC/RESP FSM.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie (no last-grant pointer).
module alu_arbiter
  import ul8_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic [OP_W-1:0]   req0_op,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_z,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  input  logic [OP_W-1:0]   req1_op,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_z,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] alu_x_out,
  output logic [DATA_W-1:0] alu_y_out,
  output logic [OP_W-1:0]   alu_op_out,
  input  logic [DATA_W-1:0] alu_z_in
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] z_q, z_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              id_q, id_d;
  logic              last_ptr;
  logic [1:0]        grant;
  logic              rsp_ready_sel;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // A constant "last was 1" makes the grant unit favour requester 0 on every tie.
  assign last_ptr = 1'b1;
`else
  logic last_q, last_d;
  assign last_ptr = last_q;
`endif

  alu_arb_grant u_grant (
    .valid_i ({req1_valid, req0_valid}),
    .last_i  (last_ptr),
    .grant_o (grant)
  );

  assign rsp_ready_sel = id_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    op_d    = op_q;
    id_d    = id_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          id_d    = grant[1];
          x_d     = grant[1] ? req1_x  : req0_x;
          y_d     = grant[1] ? req1_y  : req0_y;
          op_d    = grant[1] ? req1_op : req0_op;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d  = grant[1];
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        z_d     = alu_z_in;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_sel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      op_q    <= op_d;
      id_q    <= id_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  // Ready is the only combinational output; rst_n gates it so reset silences it at once.
  assign req0_ready = rst_n && (state_q == IDLE) && grant[0];
  assign req1_ready = rst_n && (state_q == IDLE) && grant[1];

  assign alu_x_out  = (state_q == EXEC) ? x_q  : '0;
  assign alu_y_out  = (state_q == EXEC) ? y_q  : '0;
  assign alu_op_out = (state_q == EXEC) ? op_q : '0;

  assign rsp0_valid = (state_q == RESP) && !id_q;
  assign rsp1_valid = (state_q == RESP) &&  id_q;
  assign rsp0_z     = rsp0_valid ? z_q : '0;
  assign rsp1_z     = rsp1_valid ? z_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a reference ALU and a response scoreboard.
// Tie-order expectations follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_x, req0_y, req1_x, req1_y;
  logic [1:0] req0_op, req1_op;
  logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [7:0] rsp0_z, rsp1_z;
  logic [7:0] alu_x_out, alu_y_out, alu_z_in;
  logic [1:0] alu_op_out;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       id;
    logic [7:0] z;
  } exp_t;

  exp_t sb[$];
  logic gl[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  // Reference ALU: 00 add, 01 nand, 10 sub, 11 xor.
  function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                       input logic [1:0] op);
    case (op)
      2'b00:   return x + y;
      2'b01:   return ~(x & y);
      2'b10:   return x - y;
      default: return x ^ y;
    endcase
  endfunction

  assign alu_z_in = alu_f(alu_x_out, alu_y_out, alu_op_out);

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_z     (rsp0_z),
    .rsp0_ready (rsp0_ready),
    .req1_valid (req1_valid),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_z     (rsp1_z),
    .rsp1_ready (rsp1_ready),
    .alu_x_out  (alu_x_out),
    .alu_y_out  (alu_y_out),
    .alu_op_out (alu_op_out),
    .alu_z_in   (alu_z_in)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_op_out,
              alu_x_out, alu_y_out, rsp0_z, rsp1_z}, 40'h0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0 && !rsp0_valid && !rsp1_valid) break;
      tick();
    end
    chk(tag, sb.size(), 0);
  endtask

  // Push expectations on accept, pop and compare on each response transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) begin
        mon_e.id = 1'b0;
        mon_e.z  = alu_f(req0_x, req0_y, req0_op);
        sb.push_back(mon_e);
        gl.push_back(1'b0);
        $display("[TB] accept req0 x=%02h y=%02h op=%0d", req0_x, req0_y, req0_op);
      end
      if (req1_valid && req1_ready) begin
        mon_e.id = 1'b1;
        mon_e.z  = alu_f(req1_x, req1_y, req1_op);
        sb.push_back(mon_e);
        gl.push_back(1'b1);
        $display("[TB] accept req1 x=%02h y=%02h op=%0d", req1_x, req1_y, req1_op);
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        chk("rsp_onehot", rsp0_valid & rsp1_valid, 0);
        chk("rsp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("rsp_id", rsp1_valid, mon_e.id);
          chk("rsp_z", rsp1_valid ? rsp1_z : rsp0_z, mon_e.z);
          $display("[TB] response id=%0d z=%02h", rsp1_valid, rsp1_valid ? rsp1_z : rsp0_z);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_order;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req0_op = '0;
    req1_x = '0; req1_y = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset: outputs silent even with a request pending.
    #3;
    all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset_after_edge");
    req0_valid = 1'b0;
    rst_n = 1'b1;

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      all_zero("idle");
    end

    // Single op on requester 0.
    req0_x = 8'h20; req0_y = 8'h0D; req0_op = 2'b01; req0_valid = 1'b1;
    #1;
    chk("single_ready", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 1'b0;
    chk("single_exec_alu", {alu_x_out, alu_y_out, alu_op_out}, {8'h20, 8'h0D, 2'b01});
    chk("single_exec_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    tick();
    chk("single_rsp", {rsp0_valid, rsp1_valid, rsp0_z}, {2'b10, 8'hFF});
    chk("single_rsp_alu_idle", {alu_x_out, alu_y_out, alu_op_out}, 0);
    drain("single_drain");

    // Single op on requester 1.
    req1_x = 8'h5A; req1_y = 8'hFF; req1_op = 2'b11; req1_valid = 1'b1;
    #1;
    chk("single1_ready", {req0_ready, req1_ready}, 2'b01);
    tick();
    req1_valid = 1'b0;
    drain("single1_drain");

    // Back-to-back ties.
    gl.delete();
    req0_x = 8'h33; req0_y = 8'h0F; req0_op = 2'b00;
    req1_x = 8'h50; req1_y = 8'h21; req1_op = 2'b10;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gl.size() >= 3) break;
    end
    req0_valid = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gl.size() >= 4) break;
    end
    exp_order = 4'b0001;
`else
    exp_order = 4'b0100;
`endif
    req1_valid = 1'b0;
    chk("tie_grant_count", gl.size() >= 3, 1);
    if (gl.size() >= 3) begin
      chk("tie_order", {gl[0], gl[1], gl[2], (gl.size() > 3) ? gl[3] : 1'b0}, exp_order);
    end
    drain("tie_drain");

    // Backpressure on requester 0 while requester 1 waits.
    rsp0_ready = 1'b0;
    req0_x = 8'h81; req0_y = 8'h7F; req0_op = 2'b11; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    req1_x = 8'h10; req1_y = 8'h03; req1_op = 2'b10; req1_valid = 1'b1;
    chk("bp_exec_ready1", req1_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp0_valid, rsp0_z, req1_ready, rsp1_valid}, {1'b1, 8'hFE, 2'b00});
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    chk("bp_release", {req1_ready, rsp0_valid}, 2'b10);
    tick();
    req1_valid = 1'b0;
    drain("bp_drain");

    // Reset while an operation is in EXEC.
    req0_x = 8'h11; req0_y = 8'h22; req0_op = 2'b00; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    chk("rst_exec_alu", alu_x_out, 8'h11);
    rst_n = 1'b0;
    #1;
    all_zero("rst_exec_zero");
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    end
    req0_x = 8'h0F; req0_y = 8'h01; req0_op = 2'b00;
    req1_x = 8'hF0; req1_y = 8'h0F; req1_op = 2'b01;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_tie", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("rst_tie_drain");

    tick();
    all_zero("final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
